// File: rtl/rob_commit_ctrl_pkg.sv
// rob_commit_ctrl_pkg: shared widths and the per-entry payload of the reorder buffer.
package rob_commit_ctrl_pkg;
    localparam int ROB_W_DEF = 4;
    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
    } rob_entry_t;
endpackage

// File: rtl/rob_entry_array.sv
// rob_entry_array: ROB storage with one alloc write, one write-back port and two forwarding lookups.
module rob_entry_array
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              alloc_we,
    input  logic [ROB_W-1:0]  alloc_idx,
    input  logic [REG_W-1:0]  alloc_rd,
    input  logic              wb_we,
    input  logic              fwd_valid,
    input  logic [ROB_W-1:0]  wb_idx,
    input  logic [DATA_W-1:0] wb_value,
    input  logic [ROB_W-1:0]  head_idx,
    output logic              head_ready,
    output logic [REG_W-1:0]  head_rd,
    output logic [DATA_W-1:0] head_value,
    input  logic [ROB_W-1:0]  tag1,
    input  logic [ROB_W-1:0]  tag2,
    output logic              ready1,
    output logic [DATA_W-1:0] value1,
    output logic              ready2,
    output logic [DATA_W-1:0] value2
);
    localparam int DEPTH = 1 << ROB_W;
    logic [DEPTH-1:0] ready_q;
    rob_entry_t ent_q [DEPTH];
    logic hit1, hit2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_q <= '0;
        else if (clr) ready_q <= '0;
        else begin
            if (alloc_we) ready_q[alloc_idx] <= 1'b0;
            if (wb_we) ready_q[wb_idx] <= 1'b1;
        end
    end
    // Payload needs no reset: it is only consumed once its ready bit is set.
    always_ff @(posedge clk) begin
        if (alloc_we) ent_q[alloc_idx].rd <= alloc_rd;
        if (wb_we) ent_q[wb_idx].value <= wb_value;
    end
    assign hit1 = fwd_valid && wb_idx == tag1;
    assign hit2 = fwd_valid && wb_idx == tag2;
    assign ready1 = ready_q[tag1] | hit1;
    assign ready2 = ready_q[tag2] | hit2;
    assign value1 = hit1 ? wb_value : ent_q[tag1].value;
    assign value2 = hit2 ? wb_value : ent_q[tag2].value;
    assign head_ready = ready_q[head_idx];
    assign head_rd = ent_q[head_idx].rd;
    assign head_value = ent_q[head_idx].value;
endmodule

// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order ROB pointer/count/commit control driving the architectural register file.
module rob_commit_ctrl
    import rob_commit_ctrl_pkg::*;
#(
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              alloc_valid,
    input  logic [4:0]        alloc_rd,
    output logic              alloc_ready,
    output logic [ROB_W-1:0]  alloc_rob_id,
    output logic              need_set_reg_dep,
    output logic [4:0]        set_dep_reg_id,
    output logic [ROB_W-1:0]  set_dep_rob_id,
    input  logic              wb_valid,
    input  logic [ROB_W-1:0]  wb_rob_id,
    input  logic [31:0]       wb_value,
    input  logic [ROB_W-1:0]  need_rob_id1,
    input  logic [ROB_W-1:0]  need_rob_id2,
    output logic              rob_value1_ready,
    output logic [31:0]       rob_value1,
    output logic              rob_value2_ready,
    output logic [31:0]       rob_value2,
    output logic              need_set_reg_value,
    output logic [4:0]        set_value_reg_id,
    output logic [31:0]       set_val,
    output logic [ROB_W-1:0]  set_reg_rob_id,
    output logic              clear
);
    localparam logic [ROB_W:0] FULL = {1'b1, {ROB_W{1'b0}}};
    logic [ROB_W-1:0] head, tail, wb_off;
    logic [ROB_W:0] count;
    logic fire, commit, wb_we, head_ready;
    logic [REG_W-1:0] head_rd;
    logic [DATA_W-1:0] head_value;
    assign alloc_ready = rdy & ~flush & ~clear & (count != FULL);
    assign fire = alloc_valid & alloc_ready;
    assign alloc_rob_id = tail;
    assign set_dep_rob_id = tail;
    assign set_dep_reg_id = alloc_rd;
    assign need_set_reg_dep = fire & (alloc_rd != '0);
    // A tag is occupied when its distance from head lies inside the live window.
    assign wb_off = wb_rob_id - head;
    assign wb_we = rdy & ~flush & wb_valid & ({1'b0, wb_off} < count);
    assign commit = rdy & ~flush & (count != '0) & head_ready;
    rob_entry_array #(.ROB_W(ROB_W)) u_array (
        .clk(clk),
        .rst(rst),
        .clr(rdy & flush),
        .alloc_we(fire),
        .alloc_idx(tail),
        .alloc_rd(alloc_rd),
        .wb_we(wb_we),
        .fwd_valid(wb_valid),
        .wb_idx(wb_rob_id),
        .wb_value(wb_value),
        .head_idx(head),
        .head_ready(head_ready),
        .head_rd(head_rd),
        .head_value(head_value),
        .tag1(need_rob_id1),
        .tag2(need_rob_id2),
        .ready1(rob_value1_ready),
        .value1(rob_value1),
        .ready2(rob_value2_ready),
        .value2(rob_value2)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            need_set_reg_value <= 1'b0;
            clear <= 1'b0;
            set_value_reg_id <= '0;
            set_val <= '0;
            set_reg_rob_id <= '0;
        end else if (!rdy) begin
            need_set_reg_value <= 1'b0;
            clear <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            need_set_reg_value <= 1'b0;
            clear <= 1'b1;
        end else begin
            clear <= 1'b0;
            need_set_reg_value <= commit & (head_rd != '0);
            tail <= tail + ROB_W'(fire);
            head <= head + ROB_W'(commit);
            count <= count + (ROB_W+1)'(fire) - (ROB_W+1)'(commit);
            if (commit) begin
                set_value_reg_id <= head_rd;
                set_val <= head_value;
                set_reg_rob_id <= head;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// tb_rob_commit_ctrl: directed scenarios for rob_commit_ctrl with hand-computed expectations.
module tb_rob_commit_ctrl;
    logic clk = 1'b0, rst, rdy, flush, alloc_valid, wb_valid;
    logic [4:0] alloc_rd;
    logic [3:0] wb_rob_id, need_rob_id1, need_rob_id2;
    logic [31:0] wb_value;
    logic alloc_ready, need_set_reg_dep, rob_value1_ready, rob_value2_ready, need_set_reg_value, clear;
    logic [3:0] alloc_rob_id, set_dep_rob_id, set_reg_rob_id;
    logic [4:0] set_dep_reg_id, set_value_reg_id;
    logic [31:0] rob_value1, rob_value2, set_val;
    int n_vec = 0, n_err = 0;

    rob_commit_ctrl #(.ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
        .alloc_rob_id(alloc_rob_id), .need_set_reg_dep(need_set_reg_dep),
        .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
        .need_rob_id1(need_rob_id1), .need_rob_id2(need_rob_id2),
        .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
        .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2),
        .need_set_reg_value(need_set_reg_value), .set_value_reg_id(set_value_reg_id),
        .set_val(set_val), .set_reg_rob_id(set_reg_rob_id), .clear(clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = '0;
        wb_valid = 1'b0; wb_rob_id = '0; wb_value = '0;
        need_rob_id1 = '0; need_rob_id2 = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic alloc_n(input int n, input logic [4:0] rd);
        alloc_valid = 1'b1; alloc_rd = rd;
        for (int i = 0; i < n; i++) step();
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        n_vec++;
        if ({need_set_reg_value, clear, set_value_reg_id, set_val, set_reg_rob_id, alloc_rob_id} !== '0) begin
            n_err++;
            $display("FAIL reset_regs got nsrv=%b clr=%b rd=%0d val=%h id=%0d tail=%0d want all 0",
                     need_set_reg_value, clear, set_value_reg_id, set_val, set_reg_rob_id, alloc_rob_id);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({alloc_ready, rob_value1_ready, rob_value2_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_ready got aready=%b r1=%b r2=%b want 1 0 0", alloc_ready, rob_value1_ready, rob_value2_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        alloc_valid = 1'b1; alloc_rd = 5'd5;
        #1;
        n_vec++;
        if ({need_set_reg_dep, set_dep_reg_id, set_dep_rob_id, alloc_rob_id} !== {1'b1, 5'd5, 4'd0, 4'd0}) begin
            n_err++;
            $display("FAIL basic_dep got dep=%b reg=%0d rob=%0d id=%0d want 1 5 0 0",
                     need_set_reg_dep, set_dep_reg_id, set_dep_rob_id, alloc_rob_id);
        end
        step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_value = 32'hDEAD;
        step();
        wb_valid = 1'b0;
        n_vec++;
        if (need_set_reg_value !== 1'b0) begin
            n_err++;
            $display("FAIL basic_early got nsrv=%b want 0", need_set_reg_value);
        end
        step();
        n_vec++;
        if ({need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id} !== {1'b1, 5'd5, 32'hDEAD, 4'd0}) begin
            n_err++;
            $display("FAIL basic_commit got nsrv=%b rd=%0d val=%h id=%0d want 1 5 0000dead 0",
                     need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id);
        end
        step();
        n_vec++;
        if ({need_set_reg_value, alloc_rob_id} !== {1'b0, 4'd1}) begin
            n_err++;
            $display("FAIL basic_after got nsrv=%b tail=%0d want 0 1", need_set_reg_value, alloc_rob_id);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_rd = 5'(i + 1);
            #1;
            n_vec++;
            if ({alloc_ready, alloc_rob_id} !== {1'b1, 4'(i)}) begin
                n_err++;
                $display("FAIL fill_%0d got ready=%b id=%0d want 1 %0d", i, alloc_ready, alloc_rob_id, i);
            end
            step();
        end
        alloc_rd = 5'd7;
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_value = 32'h100;
        #1;
        n_vec++;
        if (alloc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_block got ready=%b want 0", alloc_ready);
        end
        step();
        wb_valid = 1'b0;
        n_vec++;
        if (alloc_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_commit_block got ready=%b want 0", alloc_ready);
        end
        step();
        n_vec++;
        if ({need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id} !== {1'b1, 5'd1, 32'h100, 4'd0}) begin
            n_err++;
            $display("FAIL full_commit got nsrv=%b rd=%0d val=%h id=%0d want 1 1 00000100 0",
                     need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id);
        end
        n_vec++;
        if ({alloc_ready, alloc_rob_id, need_set_reg_dep} !== {1'b1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap_accept got ready=%b id=%0d dep=%b want 1 0 1", alloc_ready, alloc_rob_id, need_set_reg_dep);
        end
        step();
        alloc_valid = 1'b0;
        n_vec++;
        if ({alloc_ready, alloc_rob_id, need_set_reg_value} !== {1'b0, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL wrap_after got ready=%b id=%0d nsrv=%b want 0 1 0", alloc_ready, alloc_rob_id, need_set_reg_value);
        end
    endtask

    task automatic test_out_of_order();
        logic [31:0] vals [3];
        vals[0] = 32'h10; vals[1] = 32'h11; vals[2] = 32'h22;
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(i + 1);
            step();
        end
        alloc_valid = 1'b0;
        wb_valid = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            wb_rob_id = 4'(i); wb_value = vals[i];
            step();
        end
        wb_valid = 1'b0;
        n_vec++;
        if (need_set_reg_value !== 1'b0) begin
            n_err++;
            $display("FAIL ooo_early got nsrv=%b want 0", need_set_reg_value);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id} !== {1'b1, 5'(i + 1), vals[i], 4'(i)}) begin
                n_err++;
                $display("FAIL ooo_commit_%0d got nsrv=%b rd=%0d val=%h id=%0d want 1 %0d %h %0d",
                         i, need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id, i + 1, vals[i], i);
            end
        end
        step();
        n_vec++;
        if (need_set_reg_value !== 1'b0) begin
            n_err++;
            $display("FAIL ooo_drain got nsrv=%b want 0", need_set_reg_value);
        end
    endtask

    task automatic test_lookup();
        do_reset();
        alloc_n(4, 5'd4);
        wb_valid = 1'b1; wb_rob_id = 4'd3; wb_value = 32'h1234;
        need_rob_id1 = 4'd3; need_rob_id2 = 4'd2;
        #1;
        n_vec++;
        if ({rob_value1_ready, rob_value1, rob_value2_ready} !== {1'b1, 32'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL lookup_fwd got r1=%b v1=%h r2=%b want 1 00001234 0", rob_value1_ready, rob_value1, rob_value2_ready);
        end
        step();
        wb_valid = 1'b0;
        #1;
        n_vec++;
        if ({rob_value1_ready, rob_value1} !== {1'b1, 32'h1234}) begin
            n_err++;
            $display("FAIL lookup_stored got r1=%b v1=%h want 1 00001234", rob_value1_ready, rob_value1);
        end
    endtask

    task automatic test_flush();
        do_reset();
        alloc_n(6, 5'd9);
        wb_valid = 1'b1; wb_rob_id = 4'd1; wb_value = 32'h77;
        step();
        wb_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_vec++;
        if ({clear, need_set_reg_value, alloc_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL flush_clear got clr=%b nsrv=%b ready=%b want 1 0 0", clear, need_set_reg_value, alloc_ready);
        end
        step();
        need_rob_id1 = 4'd1;
        #1;
        n_vec++;
        if ({clear, alloc_ready, alloc_rob_id, rob_value1_ready, need_set_reg_value} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL flush_after got clr=%b ready=%b id=%0d r1=%b nsrv=%b want 0 1 0 0 0",
                     clear, alloc_ready, alloc_rob_id, rob_value1_ready, need_set_reg_value);
        end
    endtask

    task automatic test_rd0_and_freeze();
        do_reset();
        alloc_valid = 1'b1; alloc_rd = 5'd0;
        #1;
        n_vec++;
        if ({alloc_ready, need_set_reg_dep} !== 2'b10) begin
            n_err++;
            $display("FAIL rd0_dep got ready=%b dep=%b want 1 0", alloc_ready, need_set_reg_dep);
        end
        step();
        alloc_valid = 1'b0;
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_value = 32'h99;
        step();
        wb_valid = 1'b0;
        step();
        n_vec++;
        if ({need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id} !== {1'b0, 5'd0, 32'h99, 4'd0}) begin
            n_err++;
            $display("FAIL rd0_commit got nsrv=%b rd=%0d val=%h id=%0d want 0 0 00000099 0",
                     need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id);
        end
        alloc_n(1, 5'd6);
        wb_valid = 1'b1; wb_rob_id = 4'd1; wb_value = 32'hAB;
        step();
        wb_valid = 1'b0;
        rdy = 1'b0; alloc_valid = 1'b1; alloc_rd = 5'd3; need_rob_id1 = 4'd1;
        #1;
        n_vec++;
        if ({alloc_ready, need_set_reg_dep} !== 2'b00) begin
            n_err++;
            $display("FAIL freeze_alloc got ready=%b dep=%b want 0 0", alloc_ready, need_set_reg_dep);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({need_set_reg_value, alloc_rob_id, set_reg_rob_id, rob_value1_ready, rob_value1} !== {1'b0, 4'd2, 4'd0, 1'b1, 32'hAB}) begin
                n_err++;
                $display("FAIL freeze_%0d got nsrv=%b tail=%0d cid=%0d r1=%b v1=%h want 0 2 0 1 000000ab",
                         i, need_set_reg_value, alloc_rob_id, set_reg_rob_id, rob_value1_ready, rob_value1);
            end
        end
        rdy = 1'b1; alloc_valid = 1'b0;
        step();
        n_vec++;
        if ({need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id} !== {1'b1, 5'd6, 32'hAB, 4'd1}) begin
            n_err++;
            $display("FAIL thaw_commit got nsrv=%b rd=%0d val=%h id=%0d want 1 6 000000ab 1",
                     need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_n(2, 5'd3);
        wb_valid = 1'b1; wb_rob_id = 4'd0; wb_value = 32'h5;
        step();
        wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({alloc_rob_id, need_set_reg_value} !== {4'd0, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst got tail=%0d nsrv=%b want 0 0", alloc_rob_id, need_set_reg_value);
        end
        step();
        n_vec++;
        if ({need_set_reg_value, set_val} !== {1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL async_rst_hold got nsrv=%b val=%h want 0 00000000", need_set_reg_value, set_val);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_wrap();
        test_out_of_order();
        test_lookup();
        test_flush();
        test_rd0_and_freeze();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
